// File: rtl/popcount_sequencer_if.sv
// Operand/result handshake bundle between the producer, the popcount sequencer and the consumer.
// The master drives operands and takes results; the slave is the sequencer.
interface popcount_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int SW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    out_sum;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/popcount_sequencer.sv
// Streams a WIDTH-bit operand through a shared 16-input ones counter, one chunk per cycle,
// and sums the counts that come back LAT cycles later into a saturating total.
module popcount_sequencer #(
    parameter int WIDTH = 64,
    parameter int LAT   = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    popcount_sequencer_if.slave  bus,
    output logic [15:0]          cnt_in,
    output logic                 cnt_vld,
    input  logic [4:0]           cnt_out,
    output logic                 err
);
    localparam int N  = WIDTH / 16;
    localparam int SW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(N + 1);
    localparam int AW = SW + 6;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    rcnt;
    logic [LAT-1:0]   vld_pipe;
    logic [SW-1:0]    acc;
    logic [AW-1:0]    acc_sum;
    logic [SW-1:0]    acc_nxt;
    logic             ret;
    logic             last_ret;

    // The tail of the tag pipe marks the cycle a counter result belongs to us.
    assign ret      = vld_pipe[LAT-1];
    assign last_ret = ret && (rcnt == IW'(N - 1));

    // A corrupt count (>16) can push the sum past WIDTH; clamp rather than wrap.
    assign acc_sum = AW'(acc) + AW'(cnt_out);
    assign acc_nxt = (acc_sum > AW'(WIDTH)) ? SW'(WIDTH) : acc_sum[SW-1:0];

    assign bus.out_sum = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            data_q        <= '0;
            idx           <= '0;
            rcnt          <= '0;
            vld_pipe      <= '0;
            acc           <= '0;
            cnt_in        <= '0;
            cnt_vld       <= 1'b0;
            err           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | LAT'(cnt_vld);

            if (ret) begin
                acc  <= acc_nxt;
                rcnt <= rcnt + 1'b1;
                if (cnt_out > 5'd16)
                    err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt_in       <= bus.in_data[15:0];
                        data_q       <= bus.in_data >> 16;
                        cnt_vld      <= 1'b1;
                        idx          <= IW'(1);
                        rcnt         <= '0;
                        acc          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (idx == IW'(N)) begin
                        cnt_vld <= 1'b0;
                        cnt_in  <= '0;
                        state   <= DRAIN;
                    end else begin
                        cnt_in <= data_q[15:0];
                        data_q <= data_q >> 16;
                        idx    <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_ret) begin
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_sequencer.sv
// Bench for popcount_sequencer: a delay-line ones-counter model feeds the DUT, and expected
// sums come from $countones over the operand's 16-bit chunks, clamped at WIDTH.
module tb_popcount_sequencer;
    localparam int WIDTH = 64;
    localparam int LAT   = 9;
    localparam int N     = WIDTH / 16;
    localparam int SW    = $clog2(WIDTH + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cnt_in;
    logic        cnt_vld;
    logic [4:0]  cnt_out;
    logic        err;
    int          checks = 0;
    int          errors = 0;
    bit          exp_err = 1'b0;
    bit          corrupt_arm = 1'b0;

    popcount_sequencer_if #(.WIDTH(WIDTH)) bus ();

    popcount_sequencer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cnt_in  (cnt_in),
        .cnt_vld (cnt_vld),
        .cnt_out (cnt_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    // counter16 model: result appears LAT cycles after the chunk; optionally lie about chunk 0
    logic [15:0] dq [LAT];
    logic        tq [LAT];
    logic        prev_vld;
    always @(posedge clk) begin
        prev_vld <= cnt_vld;
        dq[0]    <= cnt_in;
        tq[0]    <= corrupt_arm && cnt_vld && !prev_vld;
        for (int i = 1; i < LAT; i++) begin
            dq[i] <= dq[i-1];
            tq[i] <= tq[i-1];
        end
    end
    assign cnt_out = tq[LAT-1] ? 5'd17 : 5'($countones(dq[LAT-1]));

    // Accept one operand, check the chunk stream cycle by cycle and the result at t+N+LAT+1.
    task automatic run_op(input logic [WIDTH-1:0] d, input bit corrupt, output int exp);
        logic [15:0] ch;
        exp = 0;
        for (int k = 0; k < N; k++) begin
            ch = d[16*k +: 16];
            exp += (corrupt && k == 0) ? 17 : $countones(ch);
        end
        if (exp > WIDTH) exp = WIDTH;
        if (corrupt) exp_err = 1'b1;

        @(negedge clk);
        corrupt_arm = corrupt;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: in_ready=%b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        for (int j = 1; j <= N + LAT + 1; j++) begin
            if (j > 1) @(negedge clk);
            ch = (j <= N) ? d[16*(j-1) +: 16] : 16'h0;
            checks++;
            if (cnt_vld !== (j <= N) || cnt_in !== ch || bus.in_ready !== 1'b0 ||
                bus.out_valid !== (j == N + LAT + 1)) begin
                errors++;
                $display("FAIL stream t+%0d: vld=%b in=%h rdy=%b ov=%b want vld=%b in=%h rdy=0 ov=%b",
                         j, cnt_vld, cnt_in, bus.in_ready, bus.out_valid, j <= N, ch, j == N + LAT + 1);
            end
        end
        corrupt_arm = 1'b0;
        checks++;
        if (bus.out_sum !== SW'(exp) || err !== exp_err) begin
            errors++;
            $display("FAIL result %h: sum=%0d err=%b want sum=%0d err=%b", d, bus.out_sum, err, exp, exp_err);
        end
    endtask

    // Complete the output handshake from DONE and check the return to IDLE.
    task automatic finish_out;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL %s timeout: out_valid=%b want 1 within 100 cycles", name, bus.out_valid);
        end
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
            cnt_in !== 16'h0 || cnt_vld !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b ov=%b sum=%0d in=%h vld=%b err=%b want 1 0 0 0000 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, cnt_in, cnt_vld, err);
        end
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_all_ones;
        int s;
        run_op({WIDTH{1'b1}}, 1'b0, s);
        finish_out();
    endtask

    task automatic test_pattern;
        int s;
        run_op(64'hAAAA_0000_0F0F_8001, 1'b0, s);
        finish_out();
        run_op('0, 1'b0, s);
        finish_out();
    endtask

    task automatic test_random;
        int s;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 10; i++) begin
            d = {$urandom, $urandom};
            case (i % 3)
                0: d = d & {$urandom, $urandom};
                1: d = d | {$urandom, $urandom};
                default: ;
            endcase
            run_op(d, 1'b0, s);
            finish_out();
        end
    endtask

    task automatic test_backpressure;
        int s;
        run_op({$urandom, $urandom}, 1'b0, s);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 2);
            bus.in_data  = {WIDTH{1'b1}};
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== SW'(s) || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall c%0d: ov=%b sum=%0d rdy=%b want 1 %0d 0",
                         c, bus.out_valid, bus.out_sum, bus.in_ready, s);
            end
        end
        bus.in_valid = 1'b0;
        finish_out();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (cnt_vld !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_ignored: cnt_vld=%b in_ready=%b want 0 1", cnt_vld, bus.in_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        @(negedge clk);
        bus.in_data  = {WIDTH{1'b1}};
        wait_out("b2b_first");
        checks++;
        if (bus.out_sum !== SW'(0)) begin
            errors++; $display("FAIL b2b_sum0: sum=%0d want 0", bus.out_sum);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || cnt_vld !== 1'b0) begin
            errors++; $display("FAIL b2b_reopen: in_ready=%b cnt_vld=%b want 1 0", bus.in_ready, cnt_vld);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (cnt_vld !== 1'b1 || cnt_in !== 16'hFFFF) begin
            errors++; $display("FAIL b2b_accept: cnt_vld=%b cnt_in=%h want 1 ffff", cnt_vld, cnt_in);
        end
        wait_out("b2b_second");
        checks++;
        if (bus.out_sum !== SW'(WIDTH)) begin
            errors++; $display("FAIL b2b_sum1: sum=%0d want %0d", bus.out_sum, WIDTH);
        end
        finish_out();
    endtask

    task automatic test_reset_mid;
        int s;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom, $urandom} | 64'hFFFF_0000_0000_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
            cnt_in !== 16'h0 || cnt_vld !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b ov=%b sum=%0d in=%h vld=%b err=%b want 1 0 0 0000 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, cnt_in, cnt_vld, err);
        end
        run_op(64'h1, 1'b0, s);
        finish_out();
    endtask

    task automatic test_err;
        int s;
        run_op({WIDTH{1'b1}}, 1'b1, s);
        finish_out();
        run_op(64'h3, 1'b0, s);
        finish_out();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear: err=%b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_pattern();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
